vga_sync_monitor: RTL and testbench

Receive-side companion to the VGA sync generator. It watches the active-low `hsync`/`vsync` and the `active` strobe produced in the same clock domain, recovers horizontal and vertical position counters, and measures line length, lines per frame and active width. A lock state machine checks the measurements against the nominal 640x480 timing (800 x 525 totals) and flags errors. It sits beside the video output path as a self-check and alignment source for downstream pixel logic.

---
 rtl/vga_sync_monitor.sv | 210 +++++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor
// Watches active-low hsync/vsync and the active strobe from a VGA timing
// source in the same clock domain. Recovers pixel/line position, measures
// line length, lines per frame and active width, and runs a lock FSM that
// compares the measurements against the nominal totals.

module vga_sync_monitor #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        active_i,
  output logic [14:0] h_cnt_o,
  output logic [14:0] v_cnt_o,
  output logic [14:0] line_len_o,
  output logic [14:0] frame_lines_o,
  output logic [14:0] active_width_o,
  output logic        locked_o,
  output logic        err_o,
  output logic        new_frame_o
);

  localparam logic [14:0] CNT_MAX     = 15'h7FFF;
  localparam logic [14:0] H_TOTAL_C   = 15'(H_TOTAL);
  localparam logic [14:0] V_TOTAL_C   = 15'(V_TOTAL);
  localparam logic [14:0] H_TIMEOUT_C = 15'(2 * H_TOTAL - 1);
  localparam logic [3:0]  LOCK_FRM_C  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  // Saturating increment: sticks at the all-ones value, never wraps.
  function automatic logic [14:0] sat_inc(input logic [14:0] val);
    logic [14:0] res;
    if (val == CNT_MAX) begin
      res = val;
    end else begin
      res = val + 15'd1;
    end
    return res;
  endfunction

  // Registers and their next-state values
  logic        hs_q, vs_q;
  logic [14:0] h_cnt_q, h_cnt_d;
  logic [14:0] v_cnt_q, v_cnt_d;
  logic [14:0] a_cnt_q, a_cnt_d;
  logic [14:0] line_len_q, line_len_d;
  logic [14:0] frame_lines_q, frame_lines_d;
  logic [14:0] active_width_q, active_width_d;
  state_e      state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic        locked_q, locked_d;
  logic        err_q, err_d;
  logic        new_frame_q, new_frame_d;

  // Combinational helpers
  logic        hs_fall_s, vs_fall_s;
  logic [14:0] line_load_s, frame_load_s;
  logic        line_bad_s, frame_bad_s, timeout_s, fail_s;
  logic [3:0]  good_inc_s;

  // Edge detection and the values the checks compare against.
  always_comb begin
    hs_fall_s    = hs_q & ~hsync_i;
    vs_fall_s    = vs_q & ~vsync_i;
    line_load_s  = h_cnt_q + 15'd1;
    frame_load_s = v_cnt_q + {14'd0, hs_fall_s};
    line_bad_s   = hs_fall_s & (line_load_s != H_TOTAL_C);
    frame_bad_s  = vs_fall_s & (frame_load_s != V_TOTAL_C);
    // A missing hsync is flagged once, when the count reaches twice a line.
    timeout_s    = ~hs_fall_s & (h_cnt_q == H_TIMEOUT_C);
    fail_s       = line_bad_s | frame_bad_s | timeout_s;
    good_inc_s   = good_q + 4'd1;
  end

  // Horizontal measurement: position, line length and active width.
  always_comb begin
    h_cnt_d        = sat_inc(h_cnt_q);
    line_len_d     = line_len_q;
    active_width_d = active_width_q;
    a_cnt_d        = a_cnt_q;
    if (hs_fall_s) begin
      h_cnt_d        = 15'd0;
      line_len_d     = line_load_s;
      active_width_d = a_cnt_q;
      // The fall cycle itself belongs to the new line.
      a_cnt_d        = {14'd0, active_i};
    end else if (active_i) begin
      a_cnt_d = sat_inc(a_cnt_q);
    end else begin
      a_cnt_d = a_cnt_q;
    end
  end

  // Vertical measurement: line position and lines per frame.
  always_comb begin
    v_cnt_d       = v_cnt_q;
    frame_lines_d = frame_lines_q;
    if (vs_fall_s) begin
      // vsync wins over a coincident hsync; that hsync still counts toward the frame.
      v_cnt_d       = 15'd0;
      frame_lines_d = frame_load_s;
    end else if (hs_fall_s) begin
      v_cnt_d = sat_inc(v_cnt_q);
    end else begin
      v_cnt_d = v_cnt_q;
    end
  end

  // Lock FSM next-state and pulse outputs.
  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    err_d       = 1'b0;
    new_frame_d = 1'b0;
    case (state_q)
      SEARCH: begin
        // No checks here: the first measurements after reset are partial.
        if (vs_fall_s) begin
          state_d = MEASURE;
          good_d  = 4'd0;
        end else begin
          state_d = SEARCH;
        end
      end
      MEASURE: begin
        if (fail_s) begin
          state_d = SEARCH;
          err_d   = 1'b1;
        end else if (vs_fall_s) begin
          good_d = good_inc_s;
          if (good_inc_s == LOCK_FRM_C) begin
            state_d = LOCKED;
          end else begin
            state_d = MEASURE;
          end
        end else begin
          state_d = MEASURE;
        end
      end
      LOCKED: begin
        if (fail_s) begin
          state_d = SEARCH;
          err_d   = 1'b1;
        end else if (vs_fall_s) begin
          state_d     = LOCKED;
          new_frame_d = 1'b1;
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = SEARCH;
        good_d  = 4'd0;
      end
    endcase
    locked_d = (state_d == LOCKED);
  end

  // State and measurement registers; reset clears everything immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hs_q           <= 1'b1;
      vs_q           <= 1'b1;
      h_cnt_q        <= 15'd0;
      v_cnt_q        <= 15'd0;
      a_cnt_q        <= 15'd0;
      line_len_q     <= 15'd0;
      frame_lines_q  <= 15'd0;
      active_width_q <= 15'd0;
      state_q        <= SEARCH;
      good_q         <= 4'd0;
      locked_q       <= 1'b0;
      err_q          <= 1'b0;
      new_frame_q    <= 1'b0;
    end else begin
      hs_q           <= hsync_i;
      vs_q           <= vsync_i;
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      a_cnt_q        <= a_cnt_d;
      line_len_q     <= line_len_d;
      frame_lines_q  <= frame_lines_d;
      active_width_q <= active_width_d;
      state_q        <= state_d;
      good_q         <= good_d;
      locked_q       <= locked_d;
      err_q          <= err_d;
      new_frame_q    <= new_frame_d;
    end
  end

  assign h_cnt_o        = h_cnt_q;
  assign v_cnt_o        = v_cnt_q;
  assign line_len_o     = line_len_q;
  assign frame_lines_o  = frame_lines_q;
  assign active_width_o = active_width_q;
  assign locked_o       = locked_q;
  assign err_o          = err_q;
  assign new_frame_o    = new_frame_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor using a scaled-down raster (40 x 12) so that
// several lock/relock cycles and the counter saturation fit in a short run.

module tb_vga_sync_monitor;

  localparam int H   = 40;
  localparam int V   = 12;
  localparam int LF  = 2;
  localparam int HS0 = 33;   // hsync low for H in HS0..HS1
  localparam int HS1 = 36;
  localparam int VS0 = 9;    // vsync low for V in VS0..VS1
  localparam int VS1 = 10;
  localparam int AW  = 32;   // active when H < AW and V < AH
  localparam int AH  = 8;
  localparam int SAT = 32767;

  logic        clk = 1'b0;
  logic        rst, hsync, vsync, active;
  logic [14:0] h_cnt, v_cnt, line_len, frame_lines, active_width;
  logic        locked, err, new_frame;

  vga_sync_monitor #(.H_TOTAL(H), .V_TOTAL(V), .LOCK_FRAMES(LF)) dut (
    .clk_i(clk), .rst_i(rst), .hsync_i(hsync), .vsync_i(vsync), .active_i(active),
    .h_cnt_o(h_cnt), .v_cnt_o(v_cnt), .line_len_o(line_len),
    .frame_lines_o(frame_lines), .active_width_o(active_width),
    .locked_o(locked), .err_o(err), .new_frame_o(new_frame)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x > SAT) ? SAT : x;
  endfunction

  // ---------------- reference model (event times and prefix sums) --------
  int m_t, m_th, m_cum_act, m_base_a, m_cum_hs, m_base_v, m_run;
  bit m_hs_prev, m_vs_prev;
  int e_h, e_v, e_ll, e_fl, e_aw;
  bit e_lock, e_err, e_nf;

  task automatic model_reset();
    m_t = 0; m_th = 0; m_cum_act = 0; m_base_a = 0; m_cum_hs = 0; m_base_v = 0;
    m_run = -1; m_hs_prev = 1'b1; m_vs_prev = 1'b1;
    e_h = 0; e_v = 0; e_ll = 0; e_fl = 0; e_aw = 0;
    e_lock = 1'b0; e_err = 1'b0; e_nf = 1'b0;
  endtask

  task automatic model_step(input bit hs, input bit vs, input bit act);
    bit hf, vf, tmo, lbad, fbad;
    int h_before, v_before, ll_load, fl_load;
    hf = m_hs_prev & ~hs;
    vf = m_vs_prev & ~vs;
    m_hs_prev = hs;
    m_vs_prev = vs;
    m_t++;
    h_before = sat(m_t - 1 - m_th);
    ll_load  = (h_before + 1) % 32768;
    v_before = sat(m_cum_hs - m_base_v);
    fl_load  = (v_before + int'(hf)) % 32768;
    tmo  = !hf && (h_before == 2 * H - 1);
    lbad = hf && (ll_load != H);
    fbad = vf && (fl_load != V);
    if (hf) begin
      e_ll     = ll_load;
      e_aw     = sat(m_cum_act - m_base_a);
      m_base_a = m_cum_act;
      m_th     = m_t;
    end
    m_cum_act += int'(act);
    m_cum_hs  += int'(hf);
    if (vf) begin
      e_fl     = fl_load;
      m_base_v = m_cum_hs;
    end
    e_h = sat(m_t - m_th);
    e_v = sat(m_cum_hs - m_base_v);
    // m_run: -1 while searching, else count of consecutive good frames.
    e_err = 1'b0;
    e_nf  = 1'b0;
    if (m_run < 0) begin
      if (vf) m_run = 0;
    end else if (lbad || fbad || tmo) begin
      e_err = 1'b1;
      m_run = -1;
    end else if (vf) begin
      if (m_run >= LF) e_nf = 1'b1;
      else m_run++;
    end
    e_lock = (m_run >= LF);
  endtask

  initial begin : model_proc
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step(hsync, vsync, active);
    end
  end

  // Continuous comparison against the model, away from the active edge.
  initial begin : compare_proc
    forever begin
      @(negedge clk);
      chk("m_h_cnt", h_cnt, e_h);
      chk("m_v_cnt", v_cnt, e_v);
      chk("m_line_len", line_len, e_ll);
      chk("m_frame_lines", frame_lines, e_fl);
      chk("m_active_width", active_width, e_aw);
      chk("m_locked", locked, e_lock);
      chk("m_err", err, e_err);
      chk("m_new_frame", new_frame, e_nf);
    end
  end

  // ---------------- raster generator ------------------------------------
  int g_h, g_v, g_hlen, g_vlen, g_dh, g_dv, g_short_v, g_vs_falls;
  bit g_short_frame, g_hold, g_rand, g_prev_vs, g_vs_edge;

  task automatic gen_pos(input int v, input int h);
    g_v = v; g_h = h; g_hlen = H; g_vlen = V;
  endtask

  task automatic tick();
    bit hs, vs, act;
    @(negedge clk);
    if (g_hold) begin
      hs = 1'b1; vs = 1'b1; act = 1'b0; g_dh = -1; g_dv = -1;
    end else begin
      hs  = !((g_h >= HS0) && (g_h <= HS1));
      vs  = !((g_v >= VS0) && (g_v <= VS1));
      act = (g_h < AW) && (g_v < AH);
      if (g_rand && ($urandom_range(0, 15) == 0)) act = !act;
      g_dh = g_h; g_dv = g_v;
      g_h++;
      if (g_h >= g_hlen) begin
        g_h = 0;
        g_v++;
        if (g_v >= g_vlen) begin
          g_v = 0;
          g_vlen = g_short_frame ? V - 1 : V;
          g_short_frame = 1'b0;
        end
        g_hlen = H;
        if (g_v == g_short_v) begin
          g_hlen = H - 1;
          g_short_v = -1;
        end else if (g_rand && ($urandom_range(0, 7) == 0)) begin
          g_hlen = H - 2 + int'($urandom_range(0, 4));
        end
      end
    end
    hsync = hs; vsync = vs; active = act;
    g_vs_edge = g_prev_vs && !vs;
    if (g_vs_edge) g_vs_falls++;
    g_prev_vs = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit hs, input bit vs, input bit act);
    @(negedge clk);
    hsync = hs; vsync = vs; active = act;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; hsync = 1'b1; vsync = 1'b1; active = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    g_prev_vs = 1'b1; g_vs_falls = 0; g_short_v = -1; g_short_frame = 1'b0;
    g_hold = 1'b0; g_rand = 1'b0;
  endtask

  task automatic run_to(input int v, input int h);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(g_dv == v && g_dh == h) && n < 2 * H * V);
    if (!(g_dv == v && g_dh == h)) begin
      checks++; failures++;
      $display("FAIL run_to position v=%0d h=%0d not reached", v, h);
    end
  endtask

  task automatic expect_lock(input string tag);
    int n;
    n = 0;
    g_vs_falls = 0;
    while (g_vs_falls < 3 && n < 5 * H * V) begin
      tick();
      n++;
      if (g_vs_edge && g_vs_falls == 2) chk({tag, "_pre"}, locked, 0);
    end
    chk(tag, locked, 1);
  endtask

  // ---------------- directed table after reset --------------------------
  typedef struct {
    bit hs; bit vs; bit act;
    int h; int v; int ll; int fl; int aw; bit er;
  } vec_t;
  vec_t tbl[10];

  initial begin : main
    int n, errs;
    rst = 1'b1; hsync = 1'b1; vsync = 1'b1; active = 1'b0;
    g_short_v = -1; g_prev_vs = 1'b1;

    //             hs vs act  h  v  ll fl aw err
    tbl[0] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 1, 2, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 1, 0, 0, 1, 3, 0, 2, 0};
    tbl[3] = '{0, 1, 1, 1, 1, 3, 0, 2, 0};
    tbl[4] = '{1, 1, 1, 2, 1, 3, 0, 2, 0};
    tbl[5] = '{0, 0, 0, 0, 0, 3, 2, 2, 0};
    tbl[6] = '{1, 0, 0, 1, 0, 3, 2, 2, 0};
    tbl[7] = '{0, 1, 1, 0, 1, 2, 2, 0, 1};
    tbl[8] = '{1, 0, 1, 1, 0, 2, 1, 0, 0};
    tbl[9] = '{1, 1, 0, 2, 0, 2, 1, 0, 0};

    do_reset();
    chk("rst_h_cnt", h_cnt, 0);
    chk("rst_locked", locked, 0);
    chk("rst_line_len", line_len, 0);
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].hs, tbl[i].vs, tbl[i].act);
      chk($sformatf("tbl%0d_h_cnt", i), h_cnt, tbl[i].h);
      chk($sformatf("tbl%0d_v_cnt", i), v_cnt, tbl[i].v);
      chk($sformatf("tbl%0d_line_len", i), line_len, tbl[i].ll);
      chk($sformatf("tbl%0d_frame_lines", i), frame_lines, tbl[i].fl);
      chk($sformatf("tbl%0d_active_width", i), active_width, tbl[i].aw);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].er);
    end

    // Clean timing from reset: lock on the third vsync fall.
    do_reset();
    gen_pos(0, 0);
    expect_lock("clean_lock");
    run_to(2, HS0);
    chk("clean_line_len", line_len, H);
    chk("clean_aw_visible", active_width, AW);
    run_to(VS0, 0);
    chk("clean_frame_lines", frame_lines, V);
    chk("clean_new_frame", new_frame, 1);
    tick();
    chk("clean_new_frame_1cyc", new_frame, 0);
    run_to(VS0, HS0);
    chk("clean_aw_blank", active_width, 0);

    // One short line while locked.
    g_short_v = 3;
    run_to(4, HS0);
    chk("short_line_err", err, 1);
    chk("short_line_locked", locked, 0);
    chk("short_line_len", line_len, H - 1);
    tick();
    chk("short_line_err_1cyc", err, 0);
    expect_lock("relock_line");

    // One short frame while locked.
    g_short_frame = 1'b1;
    run_to(VS0, 0);
    chk("pre_short_nf", new_frame, 1);
    run_to(VS0, 0);
    chk("short_frame_lines", frame_lines, V - 1);
    chk("short_frame_err", err, 1);
    chk("short_frame_nf", new_frame, 0);
    chk("short_frame_locked", locked, 0);
    expect_lock("relock_frame");

    // hsync (and vsync) held high while locked: one timeout, then saturation.
    g_hold = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!err && n < 3 * H);
    chk("timeout_err", err, 1);
    chk("timeout_h_cnt", h_cnt, 2 * H);
    chk("timeout_locked", locked, 0);
    errs = 0;
    for (int i = 0; i < SAT + 20; i++) begin
      tick();
      errs += int'(err);
    end
    chk("timeout_no_more_err", errs, 0);
    chk("h_cnt_saturated", h_cnt, SAT);

    // Asynchronous reset pulse between clock edges while locked.
    do_reset();
    gen_pos(0, 0);
    expect_lock("lock_before_rst");
    run_to(3, 20);
    #1 rst = 1'b1;
    #1;
    chk("arst_h_cnt", h_cnt, 0);
    chk("arst_v_cnt", v_cnt, 0);
    chk("arst_line_len", line_len, 0);
    chk("arst_frame_lines", frame_lines, 0);
    chk("arst_active_width", active_width, 0);
    chk("arst_locked", locked, 0);
    chk("arst_err", err, 0);
    chk("arst_new_frame", new_frame, 0);
    rst = 1'b0;
    expect_lock("relock_rst");

    // hsync and vsync falling together with v_cnt at V-1.
    do_reset();
    for (int i = 0; i < V - 1; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
    end
    chk("coincide_v_before", v_cnt, V - 1);
    drive(1'b0, 1'b0, 1'b0);
    chk("coincide_frame_lines", frame_lines, V);
    chk("coincide_v_cnt", v_cnt, 0);

    // Randomized raster: jittered line lengths and active, a random reset.
    do_reset();
    gen_pos(int'($urandom_range(0, V - 1)), int'($urandom_range(0, H - 1)));
    g_rand = 1'b1;
    for (int i = 0; i < 3 * H * V; i++) tick();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 3 * H * V; i++) tick();
    g_rand = 1'b0;
    for (int i = 0; i < 5 * H * V; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
